// File: rtl/rx_chain_multi_model.sv
// NCH-channel receive chain: per-channel source select, accumulate-and-dump decimation,
// and a first-word-fall-through FIFO draining through an AXI-stream master.
module rx_chain_multi_model #(
  parameter int NCH        = 2,
  parameter int IN_W       = 18,
  parameter int RATE_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3*IN_W-1:0]     dds_i,
  input  logic [NCH-1:0]        rx_rst_n_i,
  input  logic [NCH*RATE_W-1:0] rate_i,
  input  logic [NCH*2-1:0]      dds_source_i,
  input  logic [NCH-1:0]        axis_tready_i,
  output logic [NCH-1:0]        axis_tvalid_o,
  output logic [NCH*32-1:0]     axis_tdata_o,
  output logic [NCH-1:0]        overflow_o
);

  localparam int ACC_W = IN_W + RATE_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  if (ACC_W > 32) begin : g_bad_width
    $error("rx_chain_multi_model: IN_W+RATE_W must not exceed 32");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rx_chain_multi_model: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("rx_chain_multi_model: NCH must be in 1..8");
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic                    ch_rst;
    logic [1:0]              src;
    logic [RATE_W-1:0]       rate_raw;
    logic [RATE_W-1:0]       rate_eff;
    logic signed [IN_W-1:0]  sample;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [RATE_W-1:0]       cnt;
    logic [RATE_W-1:0]       r_q;
    logic                    dump;
    logic [31:0]             dump_data;

    logic [31:0]             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        count;
    logic [31:0]             last_q;
    logic                    ovf_q;
    logic                    valid;
    logic                    full;
    logic                    pop;
    logic                    push_ok;

    assign ch_rst   = rst | ~rx_rst_n_i[c];
    assign src      = dds_source_i[2*c +: 2];
    assign rate_raw = rate_i[c*RATE_W +: RATE_W];
    assign rate_eff = (rate_raw == '0) ? RATE_W'(1) : rate_raw;

    always_comb begin
      // NOTE: default first so every path assigns sample and no latch is inferred.
      sample = IN_W'(1);
      case (src)
        2'd0:    sample = dds_i[0      +: IN_W];
        2'd1:    sample = dds_i[IN_W   +: IN_W];
        2'd2:    sample = dds_i[2*IN_W +: IN_W];
        default: sample = IN_W'(1);
      endcase
    end

    assign sum       = acc + {{RATE_W{sample[IN_W-1]}}, sample};
    assign dump      = (cnt == r_q - RATE_W'(1));
    assign dump_data = {{(33-ACC_W){sum[ACC_W-1]}}, sum[ACC_W-2:0]};

    // Rate is re-latched while held in reset and at each dump, so a new rate
    // only ever governs a whole output sample.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking for all state so every register sees pre-edge values.
      if (ch_rst) begin
        acc <= '0;
        cnt <= '0;
        r_q <= rate_eff;
      end else if (dump) begin
        acc <= '0;
        cnt <= '0;
        r_q <= rate_eff;
      end else begin
        acc <= sum;
        cnt <= cnt + RATE_W'(1);
      end
    end

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = valid & axis_tready_i[c];
    assign push_ok = dump & (~full | pop);

    // NOTE: storage is not reset; pointers and count gate it, so stale words never reach the output.
    always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= dump_data;
    end

    always_ff @(posedge clk) begin
      if (ch_rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        last_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          last_q <= mem[rd_ptr];
        end
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        count <= count + CNT_W'(push_ok) - CNT_W'(pop);
        if (dump & full & ~pop) ovf_q <= 1'b1;
      end
    end

    // Empty FIFO keeps presenting the last word that left it.
    assign axis_tvalid_o[c]          = valid;
    assign axis_tdata_o[c*32 +: 32]  = valid ? mem[rd_ptr] : last_q;
    assign overflow_o[c]             = ovf_q;
  end

endmodule

// File: tb/tb_rx_chain_multi_model.sv
// Self-checking bench for rx_chain_multi_model: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_rx_chain_multi_model;

  localparam int NCH        = 2;
  localparam int IN_W       = 18;
  localparam int RATE_W     = 10;
  localparam int FIFO_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3*IN_W-1:0]     dds_i;
  logic [NCH-1:0]        rx_rst_n_i;
  logic [NCH*RATE_W-1:0] rate_i;
  logic [NCH*2-1:0]      dds_source_i;
  logic [NCH-1:0]        axis_tready_i;
  logic [NCH-1:0]        axis_tvalid_o;
  logic [NCH*32-1:0]     axis_tdata_o;
  logic [NCH-1:0]        overflow_o;

  always #5 clk = ~clk;

  rx_chain_multi_model #(
    .NCH(NCH), .IN_W(IN_W), .RATE_W(RATE_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dds_i         (dds_i),
    .rx_rst_n_i    (rx_rst_n_i),
    .rate_i        (rate_i),
    .dds_source_i  (dds_source_i),
    .axis_tready_i (axis_tready_i),
    .axis_tvalid_o (axis_tvalid_o),
    .axis_tdata_o  (axis_tdata_o),
    .overflow_o    (overflow_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: inputs collected since the last output, and the FIFO as a queue.
  int win    [NCH][$];
  int fq     [NCH][$];
  int last_v [NCH];
  bit ovf_m  [NCH];
  int r_cur  [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff_rate(input int c);
    int r;
    r = int'(rate_i[c*RATE_W +: RATE_W]);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int sample_of(input int c);
    int s;
    logic signed [IN_W-1:0] v;
    s = int'(dds_source_i[2*c +: 2]);
    if (s == 3) return 1;
    v = dds_i[s*IN_W +: IN_W];
    return int'(v);
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit pop;
      bit has_push;
      int total;
      if (rst || !rx_rst_n_i[c]) begin
        win[c].delete();
        fq[c].delete();
        last_v[c] = 0;
        ovf_m[c]  = 1'b0;
        r_cur[c]  = eff_rate(c);
      end else begin
        pop      = (fq[c].size() > 0) && axis_tready_i[c];
        has_push = 1'b0;
        total    = 0;
        win[c].push_back(sample_of(c));
        if (win[c].size() == r_cur[c]) begin
          for (int i = 0; i < win[c].size(); i++) total += win[c][i];
          win[c].delete();
          r_cur[c] = eff_rate(c);
          has_push = 1'b1;
        end
        if (pop) last_v[c] = fq[c].pop_front();
        if (has_push) begin
          if (fq[c].size() < FIFO_DEPTH) fq[c].push_back(total);
          else ovf_m[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    for (int c = 0; c < NCH; c++) begin
      bit exp_valid;
      int exp_data;
      exp_valid = (fq[c].size() > 0);
      exp_data  = exp_valid ? fq[c][0] : last_v[c];
      check($sformatf("ch%0d tvalid", c), 32'(axis_tvalid_o[c]), 32'(exp_valid));
      check($sformatf("ch%0d tdata", c), axis_tdata_o[c*32 +: 32], exp_data);
      check($sformatf("ch%0d overflow", c), 32'(overflow_o[c]), 32'(ovf_m[c]));
    end
  endtask

  // One clock: advance the model with the inputs about to be sampled, then compare.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic set_rate(input int c, input int v);
    rate_i[c*RATE_W +: RATE_W] = RATE_W'(v);
  endtask

  task automatic set_src(input int c, input int v);
    dds_source_i[2*c +: 2] = 2'(v);
  endtask

  task automatic set_dds(input int k, input int v);
    dds_i[k*IN_W +: IN_W] = IN_W'(v);
  endtask

  initial begin
    bit prev_rst;
    bit prev_n [NCH];

    rst           = 1'b1;
    rx_rst_n_i    = '0;
    rate_i        = '0;
    dds_source_i  = '1;
    axis_tready_i = '0;
    dds_i         = '0;

    // Reset values
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("reset tvalid", 32'(axis_tvalid_o), 32'd0);
    check("reset tdata", axis_tdata_o[31:0] | axis_tdata_o[63:32], 32'd0);
    check("reset overflow", 32'(overflow_o), 32'd0);

    // Unit source, R=4
    set_rate(0, 4); set_src(0, 3); axis_tready_i[0] = 1'b1;
    cycle();
    rx_rst_n_i[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      check("unit r4 tvalid", 32'(axis_tvalid_o[0]), 32'(e % 4 == 0));
      if (e % 4 == 0) check("unit r4 tdata", axis_tdata_o[31:0], 32'h0000_0004);
    end

    // Signed DDS, R=10 then 2 mid-sample
    rx_rst_n_i[0] = 1'b0; set_rate(0, 10); set_src(0, 0); set_dds(0, -3);
    set_dds(1, 5); set_dds(2, 9);
    cycle();
    rx_rst_n_i[0] = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      cycle();
      if (e == 10 || e == 20) begin
        check("dds r10 tvalid", 32'(axis_tvalid_o[0]), 32'd1);
        check("dds r10 tdata", axis_tdata_o[31:0], 32'hFFFF_FFE2);
      end
      if (e == 22 || e == 24) begin
        check("dds r2 tvalid", 32'(axis_tvalid_o[0]), 32'd1);
        check("dds r2 tdata", axis_tdata_o[31:0], 32'hFFFF_FFFA);
      end
      if (e == 13) set_rate(0, 2);
    end

    // Backpressure and overflow, R=1
    rx_rst_n_i[0] = 1'b0; set_rate(0, 1); set_src(0, 3); axis_tready_i[0] = 1'b0;
    cycle();
    rx_rst_n_i[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      cycle();
      if (e == 1) begin
        check("bp first tvalid", 32'(axis_tvalid_o[0]), 32'd1);
        check("bp first tdata", axis_tdata_o[31:0], 32'd1);
      end
      if (e == 4) check("bp overflow before drop", 32'(overflow_o[0]), 32'd0);
      if (e == 5) check("bp overflow after drop", 32'(overflow_o[0]), 32'd1);
    end
    axis_tready_i[0] = 1'b1; set_src(0, 0); set_dds(0, 7);
    for (int b = 0; b < 8; b++) begin
      check("bp drain tvalid", 32'(axis_tvalid_o[0]), 32'd1);
      check("bp drain tdata", axis_tdata_o[31:0], (b < 4) ? 32'd1 : 32'd7);
      cycle();
    end
    check("bp overflow sticky", 32'(overflow_o[0]), 32'd1);

    // Full FIFO with push and pop on the same edge
    rx_rst_n_i[0] = 1'b0; set_rate(0, 2); set_src(0, 3); axis_tready_i[0] = 1'b0;
    cycle();
    rx_rst_n_i[0] = 1'b1;
    repeat (9) cycle();
    axis_tready_i[0] = 1'b1;
    cycle();
    check("full push+pop overflow", 32'(overflow_o[0]), 32'd0);
    check("full push+pop tvalid", 32'(axis_tvalid_o[0]), 32'd1);
    axis_tready_i[0] = 1'b0;
    repeat (2) cycle();
    check("full occupancy kept", 32'(overflow_o[0]), 32'd1);

    // Channel isolation and mid-operation channel reset
    rx_rst_n_i = '0; set_rate(0, 3); set_rate(1, 3); set_src(0, 3); set_src(1, 3);
    axis_tready_i = 2'b01;
    cycle();
    rx_rst_n_i = '1;
    for (int e = 1; e <= 20; e++) begin
      if (e == 17) rx_rst_n_i[1] = 1'b0;
      if (e == 18) rx_rst_n_i[1] = 1'b1;
      cycle();
      check("iso ch0 tvalid", 32'(axis_tvalid_o[0]), 32'(e % 3 == 0));
      if (e % 3 == 0) check("iso ch0 tdata", axis_tdata_o[31:0], 32'd3);
      check("iso ch0 overflow", 32'(overflow_o[0]), 32'd0);
      if (e == 15) check("iso ch1 overflow", 32'(overflow_o[1]), 32'd1);
      if (e == 17) begin
        check("ch1 reset tvalid", 32'(axis_tvalid_o[1]), 32'd0);
        check("ch1 reset overflow", 32'(overflow_o[1]), 32'd0);
      end
      if (e == 19) check("ch1 partial tvalid", 32'(axis_tvalid_o[1]), 32'd0);
      if (e == 20) begin
        check("ch1 full sum tvalid", 32'(axis_tvalid_o[1]), 32'd1);
        check("ch1 full sum tdata", axis_tdata_o[63:32], 32'd3);
      end
    end

    // Randomized traffic against the model
    prev_rst = 1'b0;
    for (int c = 0; c < NCH; c++) prev_n[c] = rx_rst_n_i[c];
    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < 3; k++) set_dds(k, int'($urandom));
      rst = ($urandom_range(499) == 0);
      for (int c = 0; c < NCH; c++) begin
        prev_n[c]        = rx_rst_n_i[c];
        rx_rst_n_i[c]    = ($urandom_range(149) != 0);
        axis_tready_i[c] = ($urandom_range(3) < ((n / 500) % 4));
        if ($urandom_range(15) == 0) set_src(c, int'($urandom_range(3)));
        if (prev_n[c] && rx_rst_n_i[c] && !rst && !prev_rst && $urandom_range(40) == 0)
          set_rate(c, int'($urandom_range(12)));
      end
      prev_rst = rst;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
